// File: rtl/kbd_fifo.sv
// Buffered keyboard port for the Hack memory map: a DEPTH-entry key FIFO with a
// data register (read oldest / write pops) and a status/control register.
module kbd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [WIDTH-1:0] key_code,
    output logic             key_ready,
    input  logic [WIDTH-1:0] in,
    input  logic             address,
    input  logic             load,
    output logic [WIDTH-1:0] out,
    output logic             irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rp_reg, rp_next;
    logic [AW-1:0] wp_reg, wp_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;

    logic empty, full, push, pop, flush, ovf_clear;
    logic [AW-1:0]    wr_index;
    logic [WIDTH-1:0] status;

    // Control bits between the flush and overflow-clear bits carry no meaning.
    logic unused_in_bits;
    assign unused_in_bits = ^in[WIDTH-2:1];

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign key_ready = !full;
    assign irq       = !empty;

    assign push      = key_valid && key_ready;
    assign flush     = load && address && in[0];
    assign ovf_clear = load && address && in[WIDTH-1];
    assign pop       = load && !address && !empty;

    // A push concurrent with a flush lands at the freshly cleared slot 0.
    assign wr_index = flush ? '0 : wp_reg;

    always_comb begin
        rp_next       = rp_reg;
        wp_next       = wp_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        if (flush) begin
            rp_next    = '0;
            wp_next    = push ? AW'(1) : '0;
            count_next = push ? CW'(1) : '0;
        end else begin
            if (pop)
                rp_next = rp_reg + AW'(1);
            if (push)
                wp_next = wp_reg + AW'(1);
            if (push && !pop)
                count_next = count_reg + CW'(1);
            else if (pop && !push)
                count_next = count_reg - CW'(1);
        end

        if (key_valid && !key_ready)
            overflow_next = 1'b1;
        else if (ovf_clear)
            overflow_next = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rp_reg       <= '0;
            wp_reg       <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rp_reg       <= rp_next;
            wp_reg       <= wp_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage needs no reset; stale entries are never visible past count.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_index] <= key_code;
    end

    always_comb begin
        status            = '0;
        status[WIDTH-1]   = overflow_reg;
        status[WIDTH-2]   = full;
        status[WIDTH-3]   = empty;
        status[AW:0]      = count_reg;
    end

    assign out = address ? status : (empty ? '0 : mem[rp_reg]);

endmodule

// File: tb/tb_kbd_fifo.sv
// Testbench for kbd_fifo (WIDTH=16, DEPTH=4): directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_kbd_fifo;

    localparam int W = 16;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         key_valid = 1'b0;
    logic [W-1:0] key_code = '0;
    logic         key_ready;
    logic [W-1:0] in_data = '0;
    logic         address = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] out_data;
    logic         irq;

    always #5 clock = ~clock;

    kbd_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clock     (clock),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .in        (in_data),
        .address   (address),
        .load      (load),
        .out       (out_data),
        .irq       (irq)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: the FIFO contents as a queue plus the sticky overflow bit.
    logic [W-1:0] q[$];
    bit           ovf = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_data();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    function automatic logic [W-1:0] exp_status();
        logic [W-1:0] s;
        int n;
        n = q.size();
        s = '0;
        s[W-1] = ovf;
        s[W-2] = (n == D);
        s[W-3] = (n == 0);
        s[2:0] = 3'(n);
        return s;
    endfunction

    function automatic void model_step(bit kv, logic [W-1:0] kc, bit ld, bit adr, logic [W-1:0] din);
        bit was_full, was_empty;
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        if (ld && adr && din[0])
            q.delete();
        if (ld && !adr && !was_empty)
            void'(q.pop_front());
        if (kv && !was_full)
            q.push_back(kc);
        if (kv && was_full)
            ovf = 1'b1;
        else if (ld && adr && din[W-1])
            ovf = 1'b0;
    endfunction

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic cycle(input bit kv, input logic [W-1:0] kc, input bit ld,
                         input bit adr, input logic [W-1:0] din);
        key_valid = kv;
        key_code  = kc;
        load      = ld;
        address   = adr;
        in_data   = din;
        model_step(kv, kc, ld, adr, din);
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        load      = 1'b0;
        address   = 1'b0;
        in_data   = '0;
    endtask

    task automatic rd(input string tag, input bit adr, input logic [W-1:0] exp);
        address = adr;
        #1;
        chk(tag, out_data, exp);
        address = 1'b0;
    endtask

    task automatic check_all(input string tag);
        rd({tag, ".data"}, 1'b0, exp_data());
        rd({tag, ".status"}, 1'b1, exp_status());
        chk({tag, ".key_ready"}, {15'b0, key_ready}, {15'b0, q.size() != D});
        chk({tag, ".irq"}, {15'b0, irq}, {15'b0, q.size() != 0});
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all("reset");
        rd("reset_status", 1'b1, 16'h2000);
        rd("reset_data", 1'b0, 16'h0000);

        // Basic push / pop ordering
        cycle(1, 16'h0041, 0, 0, 0);
        cycle(1, 16'h0042, 0, 0, 0);
        cycle(1, 16'h0043, 0, 0, 0);
        rd("push3_data", 1'b0, 16'h0041);
        rd("push3_status", 1'b1, 16'h0003);
        chk("push3_irq", {15'b0, irq}, 16'h0001);
        cycle(0, 0, 1, 0, 16'hFFFF);
        rd("pop1_data", 1'b0, 16'h0042);
        cycle(0, 0, 1, 0, 0);
        rd("pop2_data", 1'b0, 16'h0043);
        cycle(0, 0, 1, 0, 0);
        rd("pop3_data", 1'b0, 16'h0000);
        chk("pop3_irq", {15'b0, irq}, 16'h0000);
        cycle(0, 0, 1, 0, 0);
        check_all("pop_empty");

        // Fill, overflow, clear, wrap
        for (int i = 0; i < 4; i++) cycle(1, 16'(16'h11 + i), 0, 0, 0);
        rd("full_status", 1'b1, 16'h4004);
        chk("full_key_ready", {15'b0, key_ready}, 16'h0000);
        cycle(1, 16'h0015, 0, 0, 0);
        rd("ovf_status", 1'b1, 16'hC004);
        rd("ovf_data", 1'b0, 16'h0011);
        cycle(0, 0, 1, 1, 16'h8000);
        rd("ovf_clr_status", 1'b1, 16'h4004);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 16'h0016, 0, 0, 0);
        check_all("wrap");
        rd("wrap0", 1'b0, 16'h0012);
        cycle(0, 0, 1, 0, 0);
        rd("wrap1", 1'b0, 16'h0013);
        cycle(0, 0, 1, 0, 0);
        rd("wrap2", 1'b0, 16'h0014);
        cycle(0, 0, 1, 0, 0);
        rd("wrap3", 1'b0, 16'h0016);
        cycle(0, 0, 1, 0, 0);
        check_all("wrap_empty");

        // Simultaneous push and pop
        cycle(1, 16'h0021, 0, 0, 0);
        cycle(1, 16'h0022, 0, 0, 0);
        cycle(1, 16'h0023, 1, 0, 0);
        rd("pp2_status", 1'b1, 16'h0002);
        rd("pp2_data", 1'b0, 16'h0022);
        cycle(0, 0, 1, 0, 0);
        rd("pp2_next", 1'b0, 16'h0023);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 16'h0020, 1, 0, 0);
        rd("pp0_status", 1'b1, 16'h0001);
        rd("pp0_data", 1'b0, 16'h0020);
        cycle(0, 0, 1, 0, 0);

        // Flush
        cycle(1, 16'h0031, 0, 0, 0);
        cycle(1, 16'h0032, 0, 0, 0);
        cycle(1, 16'h0034, 0, 0, 0);
        cycle(0, 0, 1, 1, 16'h0001);
        rd("flush_data", 1'b0, 16'h0000);
        rd("flush_status", 1'b1, 16'h2000);
        cycle(1, 16'h0035, 0, 0, 0);
        cycle(1, 16'h0036, 0, 0, 0);
        cycle(1, 16'h0033, 1, 1, 16'h0001);
        rd("flush_push_status", 1'b1, 16'h0001);
        rd("flush_push_data", 1'b0, 16'h0033);
        for (int i = 0; i < 3; i++) cycle(1, 16'(16'h37 + i), 0, 0, 0);
        rd("refill_status", 1'b1, 16'h4004);

        // Overflow set beats clear; full + pop still refuses the push
        cycle(1, 16'h003A, 1, 1, 16'h8000);
        rd("set_clr_status", 1'b1, 16'hC004);
        cycle(0, 0, 1, 1, 16'h8000);
        rd("clr_status", 1'b1, 16'h4004);
        cycle(1, 16'h003B, 1, 0, 0);
        rd("full_pop_status", 1'b1, 16'h8003);
        rd("full_pop_data", 1'b0, 16'h0037);
        check_all("full_pop");
        cycle(0, 0, 1, 1, 16'h8001);
        rd("flush_clr_status", 1'b1, 16'h2000);

        // Asynchronous reset mid-cycle with count=3
        for (int i = 0; i < 3; i++) cycle(1, 16'(16'h51 + i), 0, 0, 0);
        rd("pre_reset_status", 1'b1, 16'h0003);
        reset = 1'b1;
        q.delete();
        ovf = 1'b0;
        rd("areset_status", 1'b1, 16'h2000);
        rd("areset_data", 1'b0, 16'h0000);
        chk("areset_key_ready", {15'b0, key_ready}, 16'h0001);
        chk("areset_irq", {15'b0, irq}, 16'h0000);
        reset = 1'b0;
        cycle(1, 16'h0007, 0, 0, 0);
        rd("post_reset_data", 1'b0, 16'h0007);
        rd("post_reset_status", 1'b1, 16'h0001);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit kv, ld, adr;
            logic [W-1:0] kc, din;
            kv  = ($urandom_range(0, 2) != 0);
            kc  = 16'($urandom_range(1, 16'hFFFF));
            ld  = ($urandom_range(0, 2) == 0);
            adr = ($urandom_range(0, 3) == 0);
            din = 16'($urandom);
            if ($urandom_range(0, 7) != 0) din[0] = 1'b0;
            cycle(kv, kc, ld, adr, din);
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_fifo.md
# kbd_fifo

Buffered, parametrised keyboard port for the Hack memory map. It replaces the constant-value keyboard register with a DEPTH-entry FIFO fed by a valid/ready key source. The CPU reads it through the keyboard slot of `Memory`, and a CPU write to that slot acknowledges and pops the oldest key. A second register exposes status and control: count, full, empty, sticky overflow and flush.

## Interface
- WIDTH, 16, key code and data bus width; must be ≥ clog2(DEPTH)+4
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- key_valid  in  1  source offers key_code this cycle
- key_code  in  WIDTH  key value; 0 is reserved (no key) and is never offered
- key_ready  out  1  FIFO can accept; equals !full
- in  in  WIDTH  CPU write data
- address  in  1  0 = data register, 1 = status/control register
- load  in  1  CPU write strobe for the selected register
- out  out  WIDTH  CPU read data, combinational from address and state
- irq  out  1  high while FIFO non-empty

## Operation
- Storage: DEPTH×WIDTH array, read pointer rp and write pointer wp (clog2(DEPTH) bits, wrap modulo DEPTH), and count (clog2(DEPTH)+1 bits, 0..DEPTH).
- empty = (count==0); full = (count==DEPTH).
- Push: key_valid && key_ready. Writes key_code at wp, wp+1.
- Pop: load && address==0 && !empty. rp+1. Write data `in` is ignored.
- Data read (address=0): mem[rp] when !empty, else 16'h0000 (Hack "no key" convention).
- Status read (address=1):
  - bit WIDTH-1 = overflow
  - bit WIDTH-2 = full
  - bit WIDTH-3 = empty
  - bits [clog2(DEPTH):0] = count
  - all other bits 0
- Control write (load && address==1):
  - in[0]=1 flushes: rp=wp=0, count=0.
  - in[WIDTH-1]=1 clears overflow.
  - Other bits are ignored.
- overflow: sticky; set when key_valid && !key_ready.
- Count update: push only +1; pop only −1; push and pop together leaves count unchanged, and both pointers advance.
- Priorities:
  - Pop on empty is a no-op.
  - Push and pop in the same cycle on empty: push accepted, pop ignored, count becomes 1.
  - Flush and push in the same cycle: flush first, then the push lands at index 0 (count=1, wp=1).
  - Overflow set and clear in the same cycle: set wins.
  - key_ready is derived from pre-edge state only. A full FIFO with a concurrent pop still refuses the push (no pass-through) and sets overflow.
- Reset (asynchronous, any time, including mid-push or mid-pop):
  - rp=wp=count=0, overflow=0.
  - Outputs settle to key_ready=1, irq=0, data read 0, status read = empty bit only.
  - Array contents are don't-care.

## Timing
- Read path is combinational: out is valid in the same cycle as an address change, as with RAM8K.
- Push latency: a key accepted at edge N is visible on a data read and on irq after edge N.
- Pop: the next key appears on a data read after the pop edge. Back-to-back pops on consecutive cycles are supported.
- Throughput: one push and one pop per cycle.
- key_ready and irq are combinational from count only. They have no combinational path from key_valid or load.
- Integration: `Memory` clocks its targets on !clock, and this block takes that same inverted clock on its clock port.

## Test plan
All scenarios use WIDTH=16, DEPTH=4.
- Reset then idle: key_ready=1, irq=0, data read 0x0000, status read 0x2000 (empty=1, count=0).
- Push 0x0041, 0x0042, 0x0043 on consecutive cycles:
  - data read 0x0041, status count=3, irq=1.
  - Three pops return 0x0042, 0x0043, then 0x0000; irq=0 after the third pop.
- Push 4 keys (0x11..0x14), then offer 0x15:
  - key_ready=0 and full=1 (status 0x4004) before the fifth offer.
  - 0x15 is dropped and overflow=1 (status 0xC004).
  - Pop then push 0x16 gives read order 0x12, 0x13, 0x14, 0x16 (pointer wrap).
- Simultaneous push and pop:
  - With count=2: count stays 2 and order is preserved.
  - With count=0: push 0x20 together with pop gives count=1 and data read 0x20.
- Control writes:
  - Write 0x8000 to status: overflow clears, count unchanged.
  - Write 0x0001 with 3 entries: count=0, data read 0.
  - Flush with a concurrent push of 0x33: count=1, data read 0x33.
  - Overflow set and clear in the same cycle: overflow stays 1.
- Async reset asserted mid-cycle with count=3: outputs return to reset values before the next clock edge. After release, a push of 0x07 reads back 0x07 with count=1.
